// File: rtl/mod_exp_pkg.sv
// Shared constants, widths and FSM encoding for the mod_exp byte-stream wrapper.
// Also carries the P-192 modulus used by mont_exp and its benches.
package mod_exp_pkg;

    localparam int K    = 192;
    localparam int NB   = 24;
    localparam int TO_W = 20;

    typedef enum logic [2:0] {
        S_IDLE,
        S_RX_X,
        S_RX_Y,
        S_START,
        S_ARM,
        S_WAIT,
        S_TX
    } state_t;

    localparam logic [191:0] P192 =
        192'hFFFFFFFF_FFFFFFFF_FFFFFFFF_FFFFFFFE_FFFFFFFF_FFFFFFFF;

endpackage

// File: rtl/byte_shreg.sv
// Wide operand register: parallel load, or shift left one byte per step.
// The byte leaving the top is read directly from q by the parent.
module byte_shreg #(
    parameter int W = 192
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         load,
    input  logic [W-1:0] din,
    input  logic         shift,
    input  logic [7:0]   byte_in,
    output logic [W-1:0] q
);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            q <= '0;
        end else if (load) begin
            q <= din;
        end else if (shift) begin
            q <= {q[W-9:0], byte_in};
        end
    end

endmodule

// File: rtl/mod_exp_io.sv
// Byte-stream front/back end around mont_exp: collects x and y, starts the
// exponentiation, returns z big-endian, and flags a hung run via a watchdog.
import mod_exp_pkg::*;

module mod_exp_io #(
    parameter int K    = mod_exp_pkg::K,
    parameter int NB   = mod_exp_pkg::NB,
    parameter int TO_W = mod_exp_pkg::TO_W
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic [7:0]   in_data,
    input  logic         in_valid,
    output logic         in_ready,
    output logic [7:0]   out_data,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [K-1:0] exp_x,
    output logic [K-1:0] exp_y,
    output logic         exp_start,
    input  logic         exp_done,
    input  logic [K-1:0] exp_z,
    output logic         busy,
    output logic         err
);

    localparam logic [4:0] LAST = 5'(NB - 1);

    state_t            state;
    state_t            state_nx;
    logic [4:0]        cnt;
    logic [TO_W-1:0]   wd;
    logic              in_acc;
    logic              out_acc;
    logic              last;
    logic              wd_full;
    logic              timeout;
    logic [K-1:0]      z_q;

    assign in_ready  = (state == S_RX_X) || (state == S_RX_Y);
    assign out_valid = (state == S_TX);
    assign exp_start = (state == S_START);
    assign out_data  = z_q[K-1 -: 8];

    assign in_acc  = in_valid && in_ready;
    assign out_acc = out_valid && out_ready;
    assign last    = (cnt == LAST);
    assign wd_full = &wd;

    // A done that arrives on the same cycle as the timeout still wins.
    assign timeout = wd_full &&
                     ((state == S_ARM) ||
                      ((state == S_WAIT) && !exp_done));

    always_comb begin
        state_nx = state;
        unique case (state)
            S_IDLE:  state_nx = S_RX_X;
            S_RX_X:  if (in_acc && last) state_nx = S_RX_Y;
            S_RX_Y:  if (in_acc && last) state_nx = S_START;
            S_START: if (cnt == 5'd1) state_nx = S_ARM;
            S_ARM: begin
                if (wd_full)        state_nx = S_RX_X;
                else if (!exp_done) state_nx = S_WAIT;
            end
            S_WAIT: begin
                if (exp_done)     state_nx = S_TX;
                else if (wd_full) state_nx = S_RX_X;
            end
            S_TX:    if (out_acc && last) state_nx = S_RX_X;
            default: state_nx = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= S_IDLE;
        end else begin
            state <= state_nx;
        end
    end

    // Shared byte counter; START reuses it to time the two-cycle pulse.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt <= '0;
        end else if (state_nx != state) begin
            cnt <= '0;
        end else if (in_acc || out_acc || (state == S_START)) begin
            cnt <= cnt + 5'd1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wd <= '0;
        end else if ((state == S_ARM) || (state == S_WAIT)) begin
            wd <= wd + 1'b1;
        end else begin
            wd <= '0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            err <= 1'b0;
        end else if (timeout) begin
            err <= 1'b1;
        end else if (in_acc) begin
            err <= 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            busy <= 1'b0;
        end else if (in_acc && (state == S_RX_X) && (cnt == 5'd0)) begin
            busy <= 1'b1;
        end else if ((out_acc && last) || timeout) begin
            busy <= 1'b0;
        end
    end

    byte_shreg #(.W(K)) u_x (
        .clk     (clk),
        .rst_n   (rst_n),
        .load    (1'b0),
        .din     ('0),
        .shift   (in_acc && (state == S_RX_X)),
        .byte_in (in_data),
        .q       (exp_x)
    );

    byte_shreg #(.W(K)) u_y (
        .clk     (clk),
        .rst_n   (rst_n),
        .load    (1'b0),
        .din     ('0),
        .shift   (in_acc && (state == S_RX_Y)),
        .byte_in (in_data),
        .q       (exp_y)
    );

    byte_shreg #(.W(K)) u_z (
        .clk     (clk),
        .rst_n   (rst_n),
        .load    ((state == S_WAIT) && exp_done),
        .din     (exp_z),
        .shift   (out_acc),
        .byte_in (8'h00),
        .q       (z_q)
    );

endmodule

// File: tb/tb_mod_exp_io.sv
// Bench for mod_exp_io with a behavioural mont_exp stand-in whose result is
// computed by plain square-and-multiply modulo P-192.
import mod_exp_pkg::*;

module tb_mod_exp_io;

    localparam int KW = 192;
    localparam int TW = 6;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic [7:0]    in_data = 8'h00;
    logic          in_valid = 1'b0;
    logic          in_ready;
    logic [7:0]    out_data;
    logic          out_valid;
    logic          out_ready = 1'b0;
    logic [KW-1:0] exp_x;
    logic [KW-1:0] exp_y;
    logic          exp_start;
    logic          exp_done;
    logic [KW-1:0] exp_z;
    logic          busy;
    logic          err;

    int checks = 0;
    int errors = 0;
    int start_cnt = 0;
    int lat = 5;
    bit hang = 1'b0;

    logic       start_q;
    int         left;

    always #5 clk = ~clk;

    mod_exp_io #(.K(KW), .NB(24), .TO_W(TW)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_data   (in_data),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .out_data  (out_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .exp_x     (exp_x),
        .exp_y     (exp_y),
        .exp_start (exp_start),
        .exp_done  (exp_done),
        .exp_z     (exp_z),
        .busy      (busy),
        .err       (err)
    );

    function automatic logic [KW-1:0] modexp(input logic [KW-1:0] y,
                                             input logic [KW-1:0] x);
        logic [383:0] r;
        logic [383:0] b;
        logic [383:0] m;
        m = {192'd0, P192};
        r = 384'd1;
        b = {192'd0, y} % m;
        for (int i = 0; i < KW; i++) begin
            if (x[i]) r = (r * b) % m;
            b = (b * b) % m;
        end
        return r[KW-1:0];
    endfunction

    // mont_exp stand-in: done drops on the start edge, rises lat cycles later.
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            start_q  <= 1'b0;
            exp_done <= 1'b0;
            exp_z    <= '0;
            left     <= 0;
        end else begin
            start_q <= exp_start;
            if (exp_start && !start_q) begin
                exp_done <= 1'b0;
                left     <= lat;
            end else if (left != 0) begin
                left <= left - 1;
                if (left == 1 && !hang) begin
                    exp_done <= 1'b1;
                    exp_z    <= modexp(exp_y, exp_x);
                end
            end
        end
    end

    always @(posedge clk) begin
        if (exp_start) start_cnt <= start_cnt + 1;
    end

    task automatic chk(input string tag, input logic [255:0] obs,
                       input logic [255:0] expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s observed %0h expected %0h", tag, obs, expv);
        end
    endtask

    task automatic send_byte(input logic [7:0] b, input bit gaps);
        int n;
        if (gaps) repeat ($urandom_range(0, 3)) @(negedge clk);
        in_valid = 1'b1;
        in_data  = b;
        n = 0;
        while (!in_ready && n < 300) begin
            @(negedge clk);
            n++;
        end
        if (!in_ready) chk("in_ready_timeout", 256'd0, 256'd1);
        @(negedge clk);
        in_valid = 1'b0;
    endtask

    task automatic send_ops(input logic [KW-1:0] x, input logic [KW-1:0] y,
                            input bit gaps);
        for (int i = 0; i < 24; i++) send_byte(x[KW-1-8*i -: 8], gaps);
        for (int i = 0; i < 24; i++) send_byte(y[KW-1-8*i -: 8], gaps);
    endtask

    task automatic run_txn(input string tag, input logic [KW-1:0] x,
                           input logic [KW-1:0] y, input bit gaps,
                           output logic [KW-1:0] z);
        logic [KW-1:0] want;
        int s0;
        int n;
        bit stable;
        want   = modexp(y, x);
        s0     = start_cnt;
        stable = 1'b1;
        z      = '0;
        lat    = $urandom_range(1, 20);
        send_ops(x, y, gaps);
        chk({tag, "_busy_hi"}, {255'd0, busy}, 256'd1);
        for (int i = 0; i < 24; i++) begin
            n = 0;
            out_ready = gaps ? 1'($urandom_range(0, 1)) : 1'b1;
            while (!(out_valid && out_ready) && n < 500) begin
                stable &= (exp_x === x) && (exp_y === y);
                @(negedge clk);
                n++;
                out_ready = gaps ? 1'($urandom_range(0, 1)) : 1'b1;
            end
            if (!(out_valid && out_ready)) begin
                chk({tag, "_out_timeout"}, 256'd0, 256'd1);
                break;
            end
            stable &= (exp_x === x) && (exp_y === y);
            z = {z[KW-9:0], out_data};
            @(negedge clk);
        end
        out_ready = 1'b0;
        chk({tag, "_z"}, {64'd0, z}, {64'd0, want});
        chk({tag, "_start_cycles"}, 256'(start_cnt - s0), 256'd2);
        chk({tag, "_xy_stable"}, {255'd0, stable}, 256'd1);
        chk({tag, "_busy_lo"}, {255'd0, busy}, 256'd0);
    endtask

    task automatic chk_reset(input string tag);
        chk({tag, "_ctl"},
            {243'd0, in_ready, out_valid, exp_start, busy, err, out_data},
            256'd0);
        chk({tag, "_x"}, {64'd0, exp_x}, 256'd0);
        chk({tag, "_y"}, {64'd0, exp_y}, 256'd0);
    endtask

    task automatic do_reset();
        #1;
        rst_n = 1'b0;
        in_valid = 1'b0;
        out_ready = 1'b0;
        #1;
    endtask

    task automatic release_reset();
        @(negedge clk);
        rst_n = 1'b1;
        hang = 1'b0;
        repeat (2) @(negedge clk);
    endtask

    initial begin
        logic [KW-1:0] z;
        logic [KW-1:0] x;
        logic [KW-1:0] y;
        int n;

        repeat (3) @(negedge clk);
        chk_reset("reset");
        release_reset();
        chk("in_ready_after_reset", {255'd0, in_ready}, 256'd1);

        x = 192'd3;
        y = 192'd2;
        run_txn("kat", x, y, 1'b0, z);
        chk("kat_const", {64'd0, z}, 256'd8);

        for (int r = 0; r < 2; r++) begin
            x = {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
            y = {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
            run_txn("b2b", x, y, 1'b0, z);
        end

        for (int r = 0; r < 2; r++) begin
            x = {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
            y = {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
            run_txn("stall", x, y, 1'b1, z);
        end

        hang = 1'b1;
        x = {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
        send_ops(x, x, 1'b0);
        n = 0;
        while (exp_start && n < 10) begin
            @(negedge clk);
            n++;
        end
        n = 0;
        while (!err && n < 200) begin
            @(negedge clk);
            n++;
        end
        chk("wd_err", {255'd0, err}, 256'd1);
        chk("wd_window", {255'd0, (n >= 60 && n <= 68)}, 256'd1);
        chk("wd_in_ready", {255'd0, in_ready}, 256'd1);
        hang = 1'b0;
        x = {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
        y = {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
        run_txn("after_wd", x, y, 1'b0, z);
        chk("wd_err_cleared", {255'd0, err}, 256'd0);

        hang = 1'b1;
        send_ops(x, y, 1'b0);
        repeat (10) @(negedge clk);
        do_reset();
        chk_reset("rst_wait");
        release_reset();

        lat = 3;
        send_ops(y, x, 1'b0);
        n = 0;
        while (!out_valid && n < 100) begin
            @(negedge clk);
            n++;
        end
        chk("tx_reached", {255'd0, out_valid}, 256'd1);
        repeat (2) @(negedge clk);
        do_reset();
        chk_reset("rst_tx");
        release_reset();

        x = {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
        y = {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
        run_txn("post_rst", x, y, 1'b1, z);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
